// File: rtl/shift_reg_input_ctrl.sv
// Board-control front end for Shift_reg: sync + debounce 16 switches and DEL/SET buttons,
// turn events into one-cycle add/del/set pulses. Optional DEL auto-repeat under `DEL_REPEAT_EN.

module shift_reg_input_ctrl_db #(
    parameter int CNT_MAX = 1000000,
    parameter int CW      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);
    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == db)
                cnt <= '0;
            else if (cnt == CW'(CNT_MAX)) begin
                db  <= s2;
                cnt <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

module shift_reg_input_ctrl #(
    parameter int CNT_MAX    = 1000000,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        btn_del,
    input  logic        btn_set,
    output logic [3:0]  hex,
    output logic        add,
    output logic        del,
    output logic        set,
    output logic        ready
);
    localparam int NIN  = 18;
    localparam int M0   = (CNT_MAX + 5 > REPEAT_DLY) ? CNT_MAX + 5 : REPEAT_DLY;
    localparam int MAXV = (M0 > REPEAT_PER) ? M0 : REPEAT_PER;
    localparam int CW   = $clog2(MAXV);

    typedef enum logic {INIT, RUN} state_t;

    logic [NIN-1:0] raw, db, db_d;
    assign raw = {btn_set, btn_del, sw};

    for (genvar i = 0; i < NIN; i++) begin : g_db
        shift_reg_input_ctrl_db #(.CNT_MAX(CNT_MAX), .CW(CW)) u_db (
            .clk (clk),
            .rst (rst),
            .raw (raw[i]),
            .db  (db[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) db_d <= '0;
        else     db_d <= db;
    end

    state_t        state;
    logic [CW-1:0] init_cnt;
    logic [15:0]   sw_pend, sw_clr, evt_sw;
    logic          del_pend, set_pend, evt_del, evt_set, rep_evt;
    logic          g_add, g_del, g_set, g_any;
    logic [3:0]    g_idx;

`ifdef DEL_REPEAT_EN
    logic [CW-1:0] rep_cnt;
    logic          rep_phase, rep_fire;

    // First repeat after REPEAT_DLY, then every REPEAT_PER, for as long as DEL stays held.
    always_ff @(posedge clk) begin
        if (rst || state != RUN || !db[16]) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            rep_fire  <= 1'b0;
        end else if (!rep_phase && rep_cnt == CW'(REPEAT_DLY - 1)) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
            rep_fire  <= 1'b1;
        end else if (rep_phase && rep_cnt == CW'(REPEAT_PER - 1)) begin
            rep_cnt  <= '0;
            rep_fire <= 1'b1;
        end else begin
            rep_cnt  <= rep_cnt + CW'(1);
            rep_fire <= 1'b0;
        end
    end
    assign rep_evt = rep_fire & db[16];
`else
    assign rep_evt = 1'b0;
`endif

    // Switches fire on either edge, buttons only on press.
    assign evt_sw  = db[15:0] ^ db_d[15:0];
    assign evt_del = (db[16] & ~db_d[16]) | rep_evt;
    assign evt_set = db[17] & ~db_d[17];

    always_comb begin
        g_idx = '0;
        g_any = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (sw_pend[i]) begin
                g_idx = 4'(i);
                g_any = 1'b1;
            end
        end
    end

    assign g_set  = set_pend;
    assign g_del  = del_pend & ~set_pend;
    assign g_add  = g_any & ~set_pend & ~del_pend;
    assign sw_clr = g_add ? (16'd1 << g_idx) : 16'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
            sw_pend  <= '0;
            del_pend <= 1'b0;
            set_pend <= 1'b0;
            hex      <= '0;
            add      <= 1'b0;
            del      <= 1'b0;
            set      <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    // Debouncers settle on the power-up input levels; anything they report is dropped.
                    sw_pend  <= '0;
                    del_pend <= 1'b0;
                    set_pend <= 1'b0;
                    add      <= 1'b0;
                    del      <= 1'b0;
                    set      <= 1'b0;
                    if (init_cnt == CW'(CNT_MAX + 3)) begin
                        state    <= RUN;
                        ready    <= 1'b1;
                        init_cnt <= '0;
                    end else
                        init_cnt <= init_cnt + CW'(1);
                end
                RUN: begin
                    sw_pend  <= (sw_pend & ~sw_clr) | evt_sw;
                    del_pend <= (del_pend & ~g_del) | evt_del;
                    set_pend <= (set_pend & ~g_set) | evt_set;
                    add      <= g_add;
                    del      <= g_del;
                    set      <= g_set;
                    if (g_add) hex <= g_idx;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_reg_input_ctrl.sv
// Directed bench for shift_reg_input_ctrl with CNT_MAX=4 (pulse latency 8 after first sampling edge).

module tb_shift_reg_input_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        btn_del, btn_set;
    logic [3:0]  hex;
    logic        add, del, set, ready;

    shift_reg_input_ctrl #(.CNT_MAX(4), .REPEAT_DLY(20), .REPEAT_PER(10)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_del(btn_del), .btn_set(btn_set),
        .hex(hex), .add(add), .del(del), .set(set), .ready(ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0, nfail = 0;

    typedef struct {int c; logic a; logic d; logic s; logic [3:0] h;} ev_t;
    ev_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse log, sampled on the inactive edge; also polices one-hot commands.
    always @(negedge clk) begin
        if (add | del | set) begin
            ev_t e;
            e.c = cyc; e.a = add; e.d = del; e.s = set; e.h = hex;
            q.push_back(e);
            chk("onehot", 32'(add + del + set), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind: 1=add 2=del 3=set
    task automatic chk_ev(input string name, input int idx, input int c, input int kind, input logic [3:0] h);
        if (idx >= q.size()) begin
            chk({name, "_missing"}, 32'(q.size()), 32'(idx + 1));
        end else begin
            chk({name, "_cyc"}, 32'(q[idx].c), 32'(c));
            chk({name, "_kind"}, {29'd0, q[idx].s, q[idx].d, q[idx].a}, 32'(1 << (kind - 1)));
            chk({name, "_hex"}, 32'(q[idx].h), 32'(h));
        end
    endtask

    typedef struct {
        logic [15:0] sw;
        logic        bdel, bset;
        int          glitch;
        int          kind;
        logic [3:0]  eh;
    } vec_t;

    vec_t vt[11];

    initial begin
        int t;
        logic [15:0] psw;
        logic pdel, pset;

        vt[0]  = '{16'h0205, 1'b0, 1'b0, 0, 1, 4'h9};
        vt[1]  = '{16'h0005, 1'b0, 1'b0, 0, 1, 4'h9};
        vt[2]  = '{16'h000D, 1'b0, 1'b0, 3, 0, 4'h0};
        vt[3]  = '{16'h000D, 1'b0, 1'b0, 4, 0, 4'h0};
        vt[4]  = '{16'h000D, 1'b0, 1'b0, 0, 1, 4'h3};
        vt[5]  = '{16'h000C, 1'b0, 1'b0, 0, 1, 4'h0};
        vt[6]  = '{16'h800C, 1'b0, 1'b0, 0, 1, 4'hF};
        vt[7]  = '{16'h800C, 1'b1, 1'b0, 0, 2, 4'hF};
        vt[8]  = '{16'h800C, 1'b0, 1'b0, 0, 0, 4'h0};
        vt[9]  = '{16'h800C, 1'b0, 1'b1, 0, 3, 4'hF};
        vt[10] = '{16'h800C, 1'b0, 1'b0, 0, 0, 4'h0};

        rst = 1'b1; sw = 16'h0005; btn_del = 1'b0; btn_set = 1'b0;
        step(3);
        chk("reset_outs", {27'd0, hex, add, del, set, ready}, 32'd0);
        rst = 1'b0;
        t = cyc;
        q.delete();
        step(7);
        chk("ready_pre", 32'(ready), 32'd0);
        step(1);
        chk("ready_at8", 32'(ready), 32'd1);
        step(12);
        chk("init_no_pulse", 32'(q.size()), 32'd0);

        foreach (vt[i]) begin
            psw = sw; pdel = btn_del; pset = btn_set;
            q.delete();
            t = cyc;
            sw = vt[i].sw; btn_del = vt[i].bdel; btn_set = vt[i].bset;
            if (vt[i].glitch > 0) begin
                step(vt[i].glitch);
                sw = psw; btn_del = pdel; btn_set = pset;
                step(14 - vt[i].glitch);
            end else
                step(14);
            chk($sformatf("v%0d_count", i), 32'(q.size()), (vt[i].kind != 0) ? 32'd1 : 32'd0);
            if (vt[i].kind != 0)
                chk_ev($sformatf("v%0d", i), 0, t + 9, vt[i].kind, vt[i].eh);
        end

        // Four simultaneous events drain in priority order.
        q.delete();
        t = cyc;
        sw = 16'h8088; btn_del = 1'b1; btn_set = 1'b1;
        step(16);
        chk("simul_count", 32'(q.size()), 32'd4);
        chk_ev("simul_set", 0, t + 9, 3, 4'hF);
        chk_ev("simul_del", 1, t + 10, 2, 4'hF);
        chk_ev("simul_add2", 2, t + 11, 1, 4'h2);
        chk_ev("simul_add7", 3, t + 12, 1, 4'h7);
        q.delete();
        btn_del = 1'b0; btn_set = 1'b0;
        step(14);
        chk("release_none", 32'(q.size()), 32'd0);

        // Reset lands two cycles before a DEL pulse is due.
        q.delete();
        t = cyc;
        btn_del = 1'b1;
        step(6);
        rst = 1'b1;
        step(1);
        chk("midrst_outs", {27'd0, hex, add, del, set, ready}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("midrst_ready%0d", k), {30'd0, ready, add | del | set}, 32'd0);
            step(1);
        end
        chk("midrst_ready_up", 32'(ready), 32'd1);
        step(15);
        chk("midrst_no_pulse", 32'(q.size()), 32'd0);
        btn_del = 1'b0;
        step(14);
        chk("midrst_release", 32'(q.size()), 32'd0);

        // Long DEL hold: repeats only when the feature is built in.
        q.delete();
        t = cyc;
        btn_del = 1'b1;
        step(57);
        btn_del = 1'b0;
        step(30);
`ifdef DEL_REPEAT_EN
        chk("rep_count", 32'(q.size()), 32'd5);
        chk_ev("rep0", 0, t + 9, 2, 4'h0);
        chk_ev("rep1", 1, t + 29, 2, 4'h0);
        chk_ev("rep2", 2, t + 39, 2, 4'h0);
        chk_ev("rep3", 3, t + 49, 2, 4'h0);
        chk_ev("rep4", 4, t + 59, 2, 4'h0);
`else
        chk("hold_count", 32'(q.size()), 32'd1);
        chk_ev("hold_del", 0, t + 9, 2, 4'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
